// File: rtl/cmd_tx_pkg.sv
// Shared definitions for the command frame transmitter.
//   tx_state_e     : transmitter FSM states
//   SYNC_HALF_BITS : half-bits in the sync preamble (3 high, 3 low)
//   LINE_*         : {bzo, boo} drive levels
//   odd_parity()   : parity bit that gives a word plus parity odd weight
package cmd_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    GAP    = 3'd4
  } tx_state_e;

  localparam int SYNC_HALF_BITS = 6;

  localparam logic [1:0] LINE_IDLE = 2'b00;
  localparam logic [1:0] LINE_HI   = 2'b01;
  localparam logic [1:0] LINE_LO   = 2'b10;

  // Zero-extending a narrower word to 64 bits leaves its XOR unchanged.
  function automatic logic odd_parity(input logic [63:0] word);
    return ~(^word);
  endfunction

endpackage

// File: rtl/cmd_word_fifo.sv
// Synchronous show-ahead word FIFO.
//   clk_24m, rst : clock, synchronous active-high reset (empties the FIFO)
//   push, din    : write strobe and data; accepted when not full or when
//                  a pop happens on the same edge
//   pop, dout    : read strobe (ignored when empty); dout is the head word
//   full, empty  : level flags
//   count        : number of stored words, 0..DEPTH
module cmd_word_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk_24m,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees a slot, so a push while full still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_24m) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk_24m) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cmd_frame_tx.sv
// Byte-to-command packer and Manchester frame transmitter.
//   clk_24m, rst : system clock, synchronous active-high reset
//   data         : input byte, taken on each data_ready high cycle
//   data_ready   : byte strobe
//   cmd          : word currently or most recently transmitted
//   bzo, boo     : bipolar line drive, never both high
//   busy         : frame in progress (SYNC..GAP)
//   frame_done   : one-cycle pulse after the last gap half-bit
//   full         : word FIFO full
//   overflow     : sticky, a completed word was dropped
//
// FSM states:
//   state  | meaning
//   IDLE   | line idle; pops and loads the next word when FIFO non-empty
//   SYNC   | 6 half-bits: high, high, high, low, low, low
//   DATA   | WORD_W Manchester bits, MSB first
//   PARITY | one odd-parity Manchester bit (only when PARITY_EN)
//   GAP    | 2*GAP_BITS idle half-bits, busy still high
module cmd_frame_tx
  import cmd_tx_pkg::*;
#(
  parameter int BYTES_PER_WORD = 2,
  parameter int FIFO_DEPTH     = 8,
  parameter int HALF_BIT_DIV   = 287,
  parameter int PARITY_EN      = 1,
  parameter int GAP_BITS       = 4
) (
  input  logic                          clk_24m,
  input  logic                          rst,
  input  logic [7:0]                    data,
  input  logic                          data_ready,
  output logic [8*BYTES_PER_WORD-1:0]   cmd,
  output logic                          bzo,
  output logic                          boo,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          full,
  output logic                          overflow
);

  localparam int WORD_W   = 8 * BYTES_PER_WORD;
  localparam int BC_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int DIV_W    = (HALF_BIT_DIV > 1) ? $clog2(HALF_BIT_DIV) : 1;
  localparam int HALF_MAX = (2 * GAP_BITS > SYNC_HALF_BITS) ? 2 * GAP_BITS : SYNC_HALF_BITS;
  localparam int HC_W     = $clog2(HALF_MAX);
  localparam int BIT_W    = $clog2(WORD_W);
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;

  localparam logic [BC_W-1:0]  BC_LAST     = BC_W'(BYTES_PER_WORD - 1);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(HALF_BIT_DIV - 1);
  localparam logic [HC_W-1:0]  SYNC_LAST   = HC_W'(SYNC_HALF_BITS - 1);
  localparam logic [HC_W-1:0]  SYNC_HI_END = HC_W'(SYNC_HALF_BITS / 2);
  localparam logic [HC_W-1:0]  GAP_LAST    = HC_W'(2 * GAP_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(FIFO_DEPTH);

  // Packer
  logic [BC_W-1:0]   byte_cnt;
  logic [WORD_W-1:0] word_acc;
  logic [WORD_W-1:0] word_next;
  logic              word_done;

  // FIFO
  logic [WORD_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_pop;

  // Divider
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;

  // FSM registers and next values
  tx_state_e         state, state_n;
  logic [HC_W-1:0]   half_cnt, half_n;
  logic [BIT_W-1:0]  bit_cnt, bit_n;
  logic [WORD_W-1:0] shreg, shreg_n;
  logic              par_bit, par_n;
  logic [1:0]        line, line_n;
  logic              busy_n;
  logic              done_n;
  logic [WORD_W-1:0] cmd_n;

  // The first byte ends up in the MSBs after BYTES_PER_WORD shifts; the
  // cast keeps the low WORD_W bits, which also covers the 1-byte case.
  assign word_next = WORD_W'({word_acc, data});
  assign word_done = data_ready && (byte_cnt == BC_LAST);

  always_ff @(posedge clk_24m) begin
    if (rst) begin
      byte_cnt <= '0;
      word_acc <= '0;
      overflow <= 1'b0;
    end else if (data_ready) begin
      word_acc <= word_next;
      byte_cnt <= word_done ? '0 : byte_cnt + 1'b1;
      if (word_done && fifo_full && !fifo_pop) begin
        overflow <= 1'b1;
      end
    end
  end

  cmd_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_24m (clk_24m),
    .rst     (rst),
    .push    (word_done),
    .pop     (fifo_pop),
    .din     (word_next),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign full = (fifo_count == CNT_FULL);

  // Held at zero in IDLE so every frame's first half-bit is a full period.
  assign tick = (state != IDLE) && (div_cnt == DIV_LAST);

  always_ff @(posedge clk_24m) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (state == IDLE || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_24m) begin
    if (rst) begin
      state      <= IDLE;
      half_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      line       <= LINE_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cmd        <= '0;
    end else begin
      state      <= state_n;
      half_cnt   <= half_n;
      bit_cnt    <= bit_n;
      shreg      <= shreg_n;
      par_bit    <= par_n;
      line       <= line_n;
      busy       <= busy_n;
      frame_done <= done_n;
      cmd        <= cmd_n;
    end
  end

  always_comb begin
    state_n  = state;
    half_n   = half_cnt;
    bit_n    = bit_cnt;
    shreg_n  = shreg;
    par_n    = par_bit;
    line_n   = line;
    busy_n   = busy;
    done_n   = 1'b0;
    cmd_n    = cmd;
    fifo_pop = 1'b0;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_n  = fifo_dout;
          cmd_n    = fifo_dout;
          par_n    = odd_parity(64'(fifo_dout));
          line_n   = LINE_HI;
          busy_n   = 1'b1;
          half_n   = '0;
          state_n  = SYNC;
        end
      end

      SYNC: begin
        if (tick) begin
          if (half_cnt == SYNC_LAST) begin
            state_n = DATA;
            half_n  = '0;
            bit_n   = '0;
            line_n  = shreg[WORD_W-1] ? LINE_HI : LINE_LO;
          end else begin
            half_n = half_cnt + 1'b1;
            line_n = (half_n < SYNC_HI_END) ? LINE_HI : LINE_LO;
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (half_cnt == '0) begin
            half_n = 1'b1;
            line_n = shreg[WORD_W-1] ? LINE_LO : LINE_HI;
          end else begin
            half_n  = '0;
            shreg_n = {shreg[WORD_W-2:0], 1'b0};
            if (bit_cnt == BIT_LAST) begin
              if (PARITY_EN != 0) begin
                state_n = PARITY;
                line_n  = par_bit ? LINE_HI : LINE_LO;
              end else begin
                state_n = GAP;
                line_n  = LINE_IDLE;
              end
            end else begin
              bit_n  = bit_cnt + 1'b1;
              line_n = shreg[WORD_W-2] ? LINE_HI : LINE_LO;
            end
          end
        end
      end

      PARITY: begin
        if (tick) begin
          if (half_cnt == '0) begin
            half_n = 1'b1;
            line_n = par_bit ? LINE_LO : LINE_HI;
          end else begin
            half_n  = '0;
            state_n = GAP;
            line_n  = LINE_IDLE;
          end
        end
      end

      GAP: begin
        if (tick) begin
          if (half_cnt == GAP_LAST) begin
            half_n  = '0;
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            half_n = half_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_n = IDLE;
        half_n  = '0;
        line_n  = LINE_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign bzo = line[1];
  assign boo = line[0];

endmodule

// File: tb/tb_cmd_frame_tx.sv
module tb_cmd_frame_tx;

  localparam int HALF = 4;

  logic        clk;
  logic        rst;
  logic [7:0]  data;
  logic        rdy;
  logic        sel_b;

  logic        rdy_a, rdy_b;
  logic [15:0] cmd_a, cmd_b;
  logic        bzo_a, boo_a, busy_a, done_a, full_a, ovf_a;
  logic        bzo_b, boo_b, busy_b, done_b, full_b, ovf_b;

  logic [1:0]  m_line;
  logic [15:0] m_cmd;
  logic        m_busy, m_done, m_full, m_ovf;

  int n_total = 0;
  int n_pass  = 0;
  int both_a  = 0;
  int both_b  = 0;

  assign rdy_a  = rdy && !sel_b;
  assign rdy_b  = rdy && sel_b;
  assign m_line = sel_b ? {bzo_b, boo_b} : {bzo_a, boo_a};
  assign m_cmd  = sel_b ? cmd_b : cmd_a;
  assign m_busy = sel_b ? busy_b : busy_a;
  assign m_done = sel_b ? done_b : done_a;
  assign m_full = sel_b ? full_b : full_a;
  assign m_ovf  = sel_b ? ovf_b : ovf_a;

  cmd_frame_tx #(
    .BYTES_PER_WORD (2),
    .FIFO_DEPTH     (4),
    .HALF_BIT_DIV   (HALF),
    .PARITY_EN      (1),
    .GAP_BITS       (4)
  ) u_dut (
    .clk_24m    (clk),
    .rst        (rst),
    .data       (data),
    .data_ready (rdy_a),
    .cmd        (cmd_a),
    .bzo        (bzo_a),
    .boo        (boo_a),
    .busy       (busy_a),
    .frame_done (done_a),
    .full       (full_a),
    .overflow   (ovf_a)
  );

  cmd_frame_tx #(
    .BYTES_PER_WORD (2),
    .FIFO_DEPTH     (8),
    .HALF_BIT_DIV   (HALF),
    .PARITY_EN      (0),
    .GAP_BITS       (4)
  ) u_dut_np (
    .clk_24m    (clk),
    .rst        (rst),
    .data       (data),
    .data_ready (rdy_b),
    .cmd        (cmd_b),
    .bzo        (bzo_b),
    .boo        (boo_b),
    .busy       (busy_b),
    .frame_done (done_b),
    .full       (full_b),
    .overflow   (ovf_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (bzo_a && boo_a) both_a <= both_a + 1;
    if (bzo_b && boo_b) both_b <= both_b + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b);
    data = b;
    rdy  = 1'b1;
    @(negedge clk);
    rdy  = 1'b0;
  endtask

  task automatic write_word(input logic [15:0] w);
    write_byte(w[15:8]);
    write_byte(w[7:0]);
  endtask

  // Returns the number of negedges until boo is seen high (bounded).
  task automatic wait_start(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_line[0] !== 1'b1 && n < 40);
  endtask

  // Called on the first cycle of a frame; checks every cycle through the
  // frame_done cycle against an independently built half-bit sequence.
  task automatic run_frame(input logic [15:0] w, input bit par, input string tag);
    logic [1:0] sym [64];
    int nh;
    int errs;
    logic p;
    nh = 0;
    for (int i = 0; i < 3; i++) begin sym[nh] = 2'b01; nh++; end
    for (int i = 0; i < 3; i++) begin sym[nh] = 2'b10; nh++; end
    for (int b = 15; b >= 0; b--) begin
      sym[nh] = w[b] ? 2'b01 : 2'b10; nh++;
      sym[nh] = w[b] ? 2'b10 : 2'b01; nh++;
    end
    if (par) begin
      p = 1'b1;
      for (int b = 0; b < 16; b++) p = p ^ w[b];
      sym[nh] = p ? 2'b01 : 2'b10; nh++;
      sym[nh] = p ? 2'b10 : 2'b01; nh++;
    end
    for (int i = 0; i < 8; i++) begin sym[nh] = 2'b00; nh++; end

    check({tag, "_cmd"}, m_cmd, w);
    errs = 0;
    for (int i = 0; i < nh * HALF; i++) begin
      if (i > 0) @(negedge clk);
      if (m_line !== sym[i / HALF] || m_busy !== 1'b1 || m_done !== 1'b0) errs++;
    end
    check({tag, "_line_errs"}, errs, 0);
    @(negedge clk);
    check({tag, "_frame_done"}, m_done, 1'b1);
    check({tag, "_end_idle"}, {m_busy, m_line}, 3'b000);
  endtask

  initial begin
    int n;
    rst   = 1'b1;
    rdy   = 1'b0;
    data  = 8'h00;
    sel_b = 1'b0;
    do_reset();

    // reset state
    check("rst_cmd", cmd_a, 16'h0000);
    check("rst_line", {bzo_a, boo_a}, 2'b00);
    check("rst_flags", {busy_a, done_a, full_a, ovf_a}, 4'b0000);

    // single word
    write_word(16'hA53C);
    check("single_no_start_yet", m_line, 2'b00);
    wait_start(n);
    check("single_latency", n, 1);
    run_frame(16'hA53C, 1'b1, "single");

    // back-to-back burst of three words
    fork
      begin
        write_word(16'h1357);
        write_word(16'h8001);
        write_word(16'hFE10);
      end
      begin
        wait_start(n);
        check("b2b_first_start", n, 3);
        run_frame(16'h1357, 1'b1, "b2b0");
        wait_start(n);
        check("b2b_idle1", n, 1);
        run_frame(16'h8001, 1'b1, "b2b1");
        wait_start(n);
        check("b2b_idle2", n, 1);
        run_frame(16'hFE10, 1'b1, "b2b2");
      end
    join
    repeat (3) @(negedge clk);
    check("b2b_quiet", m_busy, 1'b0);

    // overflow with a busy transmitter
    do_reset();
    fork
      begin
        write_word(16'h0101);
        write_word(16'h0202);
        write_word(16'h0303);
        write_word(16'h0404);
        check("ovf_full_after4", m_full, 1'b0);
        write_word(16'h0505);
        check("ovf_full_after5", {m_full, m_ovf}, 2'b10);
        write_word(16'h0606);
        check("ovf_after6", {m_full, m_ovf}, 2'b11);
      end
      begin
        wait_start(n);
        check("ovf_start", n, 3);
        run_frame(16'h0101, 1'b1, "ovf1");
        for (int k = 2; k <= 5; k++) begin
          wait_start(n);
          check("ovf_idle", n, 1);
          run_frame({8'(k), 8'(k)}, 1'b1, "ovfk");
        end
      end
    join
    repeat (4) @(negedge clk);
    check("ovf_no_6th", {m_busy, m_full, m_ovf}, 3'b001);

    // push while full on the exact IDLE pop cycle
    do_reset();
    write_word(16'h1111);
    wait_start(n);
    check("sim_start", n, 1);
    fork
      run_frame(16'h1111, 1'b1, "sim1");
      begin
        write_word(16'h2222);
        write_word(16'h3333);
        write_word(16'h4444);
        write_word(16'h5555);
        write_byte(8'h66);
      end
    join
    check("sim_full_pre", m_full, 1'b1);
    write_byte(8'h77);
    check("sim_accept", {m_full, m_ovf, m_line}, 4'b1001);
    run_frame(16'h2222, 1'b1, "sim2");
    wait_start(n);
    run_frame(16'h3333, 1'b1, "sim3");
    wait_start(n);
    run_frame(16'h4444, 1'b1, "sim4");
    wait_start(n);
    run_frame(16'h5555, 1'b1, "sim5");
    wait_start(n);
    check("sim6_idle", n, 1);
    run_frame(16'h6677, 1'b1, "sim6");

    // reset in the middle of data bit 7
    do_reset();
    write_word(16'hA53C);
    wait_start(n);
    write_word(16'hDEAD);
    write_word(16'hBEEF);
    write_word(16'hCAFE);
    write_word(16'hF00D);
    write_byte(8'h11);
    check("mid_full", m_full, 1'b1);
    repeat (73) @(negedge clk);
    check("mid_bit7_first_half", m_line, 2'b01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_line", {bzo_a, boo_a}, 2'b00);
    check("mid_rst_flags", {busy_a, full_a, ovf_a}, 3'b000);
    repeat (3) @(negedge clk);
    check("mid_no_stale", {m_busy, m_line}, 3'b000);
    write_word(16'h5AC3);
    wait_start(n);
    check("mid_restart", n, 1);
    run_frame(16'h5AC3, 1'b1, "mid_fresh");

    // no-parity instance
    sel_b = 1'b1;
    write_word(16'hFFFF);
    wait_start(n);
    check("np_start", n, 1);
    run_frame(16'hFFFF, 1'b0, "np");
    sel_b = 1'b0;

    check("both_hi_a", both_a, 0);
    check("both_hi_b", both_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
